// File: rtl/uart_boot_loader_if.sv
// Memory write port of the UART boot loader: one-cycle word write strobe with
// word index and data. The loader drives it as master; memory or a bench observes it.
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// Serial program loader: receives a framed image over 8N1 UART, writes little-endian
// words to memory from index 0, then releases the core. Define UART_BOOT_CHECKSUM_EN
// to require a trailing XOR checksum byte after the payload.
module uart_boot_loader #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned ADDR_W = 11,
    parameter logic [31:0] ENTRY  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ser_rx_i,
    uart_boot_loader_if.master   mem,
    output logic                 cpu_run_o,
    output logic [31:0]          entry_pc_o,
    output logic                 err_o,
    output logic [ADDR_W:0]      words_loaded_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
    localparam int unsigned CAPACITY     = 32'd1 << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    typedef enum logic [2:0] {
        L_SYNC, L_LEN0, L_LEN1, L_DATA,
`ifdef UART_BOOT_CHECKSUM_EN
        L_CSUM,
`endif
        L_DONE, L_ERR
    } ld_state_e;

    // ---------------------------------------------------------------- synchronizer
    logic sync1_q, sync2_q;

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_rx_i;
            sync2_q <= sync1_q;
        end
    end

    // ---------------------------------------------------------------- RX engine
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_valid, rx_ferr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // NOTE: every signal is given a default first so no path through the block infers a latch.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                baud_cnt_d = '0;
                if (!sync2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {sync2_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid   = sync2_q;
                    rx_ferr    = !sync2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- loader
    ld_state_e         l_state_q, l_state_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        csum_q, csum_d;
    logic              run_q, err_q;
    logic [15:0]       len_full;
    logic              last_word;

    assign len_full  = {shift_q, count_q[7:0]};
    assign last_word = (32'(words_q) + 32'd1) == 32'(count_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_state_q  <= L_SYNC;
            count_q    <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            csum_q     <= '0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            l_state_q  <= l_state_d;
            count_q    <= count_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            csum_q     <= csum_d;
            run_q      <= (l_state_q == L_DONE);
            err_q      <= err_q | (l_state_d == L_ERR);
        end
    end

    always_comb begin
        l_state_d  = l_state_q;
        count_d    = count_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        words_d    = words_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        csum_d     = csum_q;

        // Write cycle: advance bookkeeping; the index stops at count-1 so it never wraps.
        if (we_q) begin
            words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
            if (last_word) begin
`ifdef UART_BOOT_CHECKSUM_EN
                l_state_d = L_CSUM;
`else
                l_state_d = L_DONE;
`endif
            end else begin
                addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end

        // A running core is never pulled back by line noise; otherwise a bad frame is fatal.
        if (rx_ferr && l_state_q != L_DONE) begin
            l_state_d = L_ERR;
        end else if (rx_valid) begin
            unique case (l_state_q)
                L_SYNC: if (shift_q == 8'hA5) l_state_d = L_LEN0;
                L_LEN0: begin
                    count_d[7:0] = shift_q;
                    l_state_d    = L_LEN1;
                end
                L_LEN1: begin
                    count_d[15:8] = shift_q;
                    byte_idx_d    = '0;
                    csum_d        = '0;
                    if (len_full == 16'd0) begin
`ifdef UART_BOOT_CHECKSUM_EN
                        l_state_d = L_CSUM;
`else
                        l_state_d = L_DONE;
`endif
                    end else if (32'(len_full) > CAPACITY) begin
                        l_state_d = L_ERR;
                    end else begin
                        l_state_d = L_DATA;
                    end
                end
                L_DATA: begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                    csum_d     = csum_q ^ shift_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {shift_q, word_q[23:0]};
                    end
                end
`ifdef UART_BOOT_CHECKSUM_EN
                L_CSUM: l_state_d = (shift_q == csum_q) ? L_DONE : L_ERR;
`endif
                default: ;
            endcase
        end
    end

    assign mem.mem_we      = we_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wdata   = wdata_q;
    assign cpu_run_o       = run_q;
    assign entry_pc_o      = ENTRY;
    assign err_o           = err_q;
    assign words_loaded_o  = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed frames plus random images,
// compared against a queue-based model of the image format.
module tb_uart_boot_loader;

    localparam int unsigned AW = 4;
    typedef logic [7:0] bq_t[$];

    logic          clk;
    logic          reset;
    logic          ser_rx;
    logic          cpu_run;
    logic [31:0]   entry_pc;
    logic          err;
    logic [AW:0]   words_loaded;

    int n_cmp = 0;
    int n_err = 0;

    uart_boot_loader_if #(.ADDR_W(AW)) bus ();

    uart_boot_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(AW), .ENTRY(32'h8000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ser_rx_i       (ser_rx),
        .mem            (bus.master),
        .cpu_run_o      (cpu_run),
        .entry_pc_o     (entry_pc),
        .err_o          (err),
        .words_loaded_o (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Write-port monitor, sampled on the falling edge.
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            we_run;
    int            we_max;

    initial begin
        we_run = 0;
        we_max = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                got_addr.push_back(bus.mem_addr);
                got_data.push_back(bus.mem_wdata);
                we_run++;
                if (we_run > we_max) we_max = we_run;
            end else begin
                we_run = 0;
            end
        end
    end

    // Reference model of the image format.
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic          exp_run, exp_err;

    function automatic void model(input bq_t b);
        int i = 0;
        int cnt;
        logic [7:0] x = 8'h00;
        exp_addr.delete();
        exp_data.delete();
        exp_run = 1'b0;
        exp_err = 1'b0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 2 >= b.size()) return;
        cnt = int'(b[i+1]) + 256 * int'(b[i+2]);
        i += 3;
        if (cnt > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            if (i + 3 >= b.size()) return;
            exp_addr.push_back(AW'(w));
            exp_data.push_back({b[i+3], b[i+2], b[i+1], b[i]});
            x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            i += 4;
        end
`ifdef UART_BOOT_CHECKSUM_EN
        if (i >= b.size()) return;
        if (b[i] == x) exp_run = 1'b1;
        else           exp_err = 1'b1;
`else
        exp_run = 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) ser_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            ser_rx = b[k];
            repeat (10) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (10) @(negedge clk);
        ser_rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_bytes(input bq_t b);
        foreach (b[i]) send_byte(b[i], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got_addr.delete();
        got_data.delete();
        we_max = 0;
    endtask

    task automatic verify(input string tag);
        repeat (10) @(negedge clk);
        check({tag, ".n_writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            check({tag, ".addr"}, 64'(got_addr[k]), 64'(exp_addr[k]));
            check({tag, ".data"}, 64'(got_data[k]), 64'(exp_data[k]));
        end
        check({tag, ".words"},    64'(words_loaded), 64'(exp_addr.size()));
        check({tag, ".cpu_run"},  64'(cpu_run), 64'(exp_run));
        check({tag, ".err"},      64'(err), 64'(exp_err));
        check({tag, ".we_width"}, 64'(we_max), (exp_addr.size() > 0) ? 64'd1 : 64'd0);
    endtask

    task automatic run_image(input string tag, input bq_t b);
        do_reset();
        model(b);
        send_bytes(b);
        verify(tag);
    endtask

    initial begin
        bq_t img;
        reset  = 1'b0;
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);

        // Outputs while held in reset
        check("rst.mem_we",    64'(bus.mem_we), 64'd0);
        check("rst.mem_addr",  64'(bus.mem_addr), 64'd0);
        check("rst.mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst.cpu_run",   64'(cpu_run), 64'd0);
        check("rst.err",       64'(err), 64'd0);
        check("rst.words",     64'(words_loaded), 64'd0);
        check("rst.entry_pc",  64'(entry_pc), 64'h8000_0000);
        reset = 1'b1;

        // Two-word program
        img = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef UART_BOOT_CHECKSUM_EN
        img.push_back(8'h69);
`endif
        run_image("two_words", img);

        // Leading junk and zero count
        img = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
`ifdef UART_BOOT_CHECKSUM_EN
        img.push_back(8'h00);
`endif
        run_image("zero_count", img);

        // Oversized count, then a plausible image that must be ignored
        img = '{8'hA5, 8'h11, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_image("oversize", img);

        // Short low glitch while idle, followed by a valid image
        do_reset();
        @(negedge clk) ser_rx = 1'b0;
        repeat (3) @(negedge clk);
        ser_rx = 1'b1;
        repeat (20) @(negedge clk);
        img = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef UART_BOOT_CHECKSUM_EN
        img.push_back(8'h08);
`endif
        model(img);
        send_bytes(img);
        verify("glitch");

        // Framing error inside the payload
        do_reset();
        send_bytes('{8'hA5, 8'h01, 8'h00});
        send_byte(8'h13, 1'b0);
        send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
        repeat (10) @(negedge clk);
        check("ferr.n_writes", 64'(got_addr.size()), 64'd0);
        check("ferr.err",      64'(err), 64'd1);
        check("ferr.cpu_run",  64'(cpu_run), 64'd0);
        check("ferr.words",    64'(words_loaded), 64'd0);

        // Reset in the middle of word 0, then a complete one-word image
        do_reset();
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE});
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.mem_we", 64'(bus.mem_we), 64'd0);
        check("midrst.words",  64'(words_loaded), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got_addr.delete();
        got_data.delete();
        we_max = 0;
        img = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_BOOT_CHECKSUM_EN
        img.push_back(8'h22);
`endif
        model(img);
        send_bytes(img);
        verify("deadbeef");
`ifdef UART_BOOT_CHECKSUM_EN
        img = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        run_image("bad_csum", img);
`endif

        // Random images; the first fills the whole memory
        for (int it = 0; it < 4; it++) begin
            int         n;
            int         junk;
            logic [7:0] x;
            logic [31:0] w;
            logic [7:0] jb;
            n    = (it == 0) ? (1 << AW) : int'($urandom_range(1, (1 << AW) - 1));
            junk = int'($urandom_range(0, 3));
            x    = 8'h00;
            img.delete();
            for (int j = 0; j < junk; j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h00;
                img.push_back(jb);
            end
            img.push_back(8'hA5);
            img.push_back(8'(n));
            img.push_back(8'h00);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                for (int m = 0; m < 4; m++) begin
                    img.push_back(w[8*m +: 8]);
                    x = x ^ w[8*m +: 8];
                end
            end
`ifdef UART_BOOT_CHECKSUM_EN
            img.push_back(x);
`endif
            run_image($sformatf("rand%0d", it), img);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Serial program loader upstream of the RV32I core.
- Receives a framed program image on ser_rx (8N1 UART), assembles little-endian 32-bit words and writes them sequentially into instruction/data memory starting at word index 0, which maps to address ENTRY.
- Holds the core in reset until the image is complete, then releases it via cpu_run.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 4)
ADDR_W, 11, memory word-address width; capacity 2**ADDR_W words
ENTRY, 32'h8000_0000, byte address of word index 0 (informational, exported on entry_pc)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
ser_rx  in  1  UART receive line, idle high, asynchronous to clk
mem_we  out  1  one-cycle word write strobe
mem_addr  out  ADDR_W  word index for the write
mem_wdata  out  32  word to write
cpu_run  out  1  1 = core may execute; 0 = hold core in reset
entry_pc  out  32  constant ENTRY, for core PC init
err  out  1  sticky error flag
words_loaded  out  ADDR_W+1  number of words written so far

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, err=0, words_loaded=0. All state is cleared immediately on reset=0, including mid-byte or mid-word; a partial word is discarded.
- ser_rx passes through a 2-flop synchronizer (initialized to 1) before any use.
- RX engine states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: synced line = 0 -> RX_START with baud counter cleared.
  - RX_START: after CLKS_PER_BIT/2 cycles, sample. 0 -> RX_DATA; 1 -> glitch, return to RX_IDLE with no byte and no error.
  - RX_DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - RX_STOP: one more sample after CLKS_PER_BIT. 1 -> byte valid for one cycle. 0 -> framing error: byte dropped, err set, loader goes to L_ERR. Either way return to RX_IDLE.
- Loader FSM (advances only on valid bytes):
  - L_SYNC: byte 0xA5 -> L_LEN0; any other byte is ignored.
  - L_LEN0: latch count[7:0] -> L_LEN1.
  - L_LEN1: latch count[15:8].
    - count == 0 -> L_DONE.
    - count > 2**ADDR_W -> L_ERR.
    - otherwise -> L_DATA.
  - L_DATA: bytes fill the word little-endian (byte 0 -> [7:0] ... byte 3 -> [31:24]). On the 4th byte, mem_we pulses high for exactly one cycle, the cycle after the byte-valid cycle. mem_addr = current index and mem_wdata = the assembled word, both held stable while mem_we=1. The index and words_loaded then increment. When words_loaded reaches count -> L_DONE (or L_CSUM with feature enabled).
  - L_DONE: cpu_run=1 from the cycle after entry, held until reset. All further bytes are ignored; mem_we stays 0.
  - L_ERR: cpu_run=0, err=1, all bytes ignored until reset.
- mem_addr never wraps. The largest index written is count-1 <= 2**ADDR_W-1.
- The baud counter is ADDR-independent, 16 bits wide, and resets to 0 at each sample point.

Optional Feature:
- Macro: UART_BOOT_CHECKSUM_EN
- Defined:
  - Adds state L_CSUM after the last data word.
  - A running 8-bit XOR of all payload bytes (data bytes only, excluding sync/length) is compared to the received checksum byte.
  - Match -> L_DONE; mismatch -> L_ERR.
  - count == 0 still expects a checksum byte of 0x00.
- Not defined: no checksum byte is expected; the last data word goes directly to L_DONE.

Test Plan (CLK_HZ=1000000, BAUD=100000, i.e. 10 clk/bit; ADDR_W=4):
- Send A5 02 00 13 05 10 00 6F 00 00 00 -> mem_we pulses twice: addr 0 data 0x00100513, addr 1 data 0x0000006F. words_loaded=2, cpu_run=1, err=0.
- Send 00 FF A5 00 00 -> leading bytes ignored, zero count; cpu_run=1 with no mem_we pulse.
- Send A5 11 00 (count 17 > 16) -> err=1, cpu_run=0, no writes. Further bytes produce no mem_we.
- 3-clock low glitch on ser_rx while idle, then a valid image -> glitch ignored, image loads normally, err=0.
- Byte 0x13 with stop bit driven 0 inside L_DATA -> err=1, no write for that word.
- Assert reset after 2 of 4 bytes of word 0, then resend a full 1-word image 0xDEADBEEF -> single write addr 0 data 0xDEADBEEF. With UART_BOOT_CHECKSUM_EN, trailer 0x22 -> cpu_run=1; trailer 0x23 -> err=1.
